// File: rtl/program_sequencer.sv
// Upstream driver that resets the processor, starts NUM_PROGS programs and times each one.
// Optional watchdog is enabled by defining PSEQ_WATCHDOG_EN.
module program_sequencer #(
  parameter int unsigned NUM_PROGS   = 3,
  parameter int unsigned INIT_CYCLES = 2,
  parameter int unsigned ACK_BLANK   = 2,
  parameter int unsigned CW          = 16,
  parameter int unsigned TIMEOUT     = 16'hFFFF
) (
  input  logic          clk,
  input  logic          init_n,
  input  logic          start,
  input  logic          dut_ack,
  output logic          dut_init,
  output logic          dut_req,
  output logic          busy,
  output logic          done,
  output logic [3:0]    prog_idx,
  output logic [CW-1:0] cycles,
  output logic          cyc_valid,
  output logic          timeout,
  output logic [2:0]    dbgState
);

  // State encoding is visible on dbgState for external checkers.
  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] INIT  = 3'd1;
  localparam logic [2:0] REQ   = 3'd2;
  localparam logic [2:0] BLANK = 3'd3;
  localparam logic [2:0] RUN   = 3'd4;
  localparam logic [2:0] LOG   = 3'd5;
  localparam logic [2:0] DONE  = 3'd6;

  localparam logic [3:0]    LAST_IDX   = 4'(NUM_PROGS - 1);
  localparam logic [7:0]    INIT_LAST  = 8'(INIT_CYCLES - 1);
  localparam logic [7:0]    BLANK_LAST = 8'(ACK_BLANK - 1);
  localparam logic [CW-1:0] TIMEOUT_C  = CW'(TIMEOUT);

  logic [2:0]    state;
  logic [7:0]    phCnt;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cntInc;
  logic          startAcc;
  logic          wdHit;
  logic          reinit;

  assign cntInc   = (cnt == {CW{1'b1}}) ? cnt : cnt + 1'b1;
  assign startAcc = ((state == IDLE) || (state == DONE)) && start;

  assign dut_init = (state == INIT);
  assign dut_req  = (state == REQ);
  assign done     = (state == DONE);
  assign dbgState = state;

`ifdef PSEQ_WATCHDOG_EN
  logic timeoutR;

  // A timed-out program leaves the processor in an unknown state, so the next one starts from INIT.
  assign wdHit = (state == RUN) && !dut_ack && (cnt == TIMEOUT_C);

  always_ff @(posedge clk) begin
    if (!init_n) begin
      timeoutR <= 1'b0;
      reinit   <= 1'b0;
    end else begin
      if (startAcc) begin
        timeoutR <= 1'b0;
        reinit   <= 1'b0;
      end else if (wdHit) begin
        timeoutR <= 1'b1;
        reinit   <= 1'b1;
      end else if (state == LOG) begin
        reinit   <= 1'b0;
      end
    end
  end

  assign timeout = timeoutR;
`else
  logic unusedTimeout;

  assign unusedTimeout = ^TIMEOUT_C;
  assign wdHit         = 1'b0;
  assign reinit        = 1'b0;
  assign timeout       = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!init_n) begin
      state     <= IDLE;
      busy      <= 1'b0;
      prog_idx  <= 4'd0;
      cnt       <= '0;
      phCnt     <= 8'd0;
      cycles    <= '0;
      cyc_valid <= 1'b0;
    end else begin
      cyc_valid <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state    <= INIT;
            busy     <= 1'b1;
            prog_idx <= 4'd0;
            cnt      <= '0;
            phCnt    <= 8'd0;
          end
        end
        INIT: begin
          if (phCnt == INIT_LAST) begin
            phCnt <= 8'd0;
            state <= REQ;
          end else begin
            phCnt <= phCnt + 8'd1;
          end
        end
        REQ: begin
          cnt   <= '0;
          phCnt <= 8'd0;
          state <= BLANK;
        end
        BLANK: begin
          // The blank window is part of the reported run length.
          cnt <= cntInc;
          if (phCnt == BLANK_LAST) begin
            phCnt <= 8'd0;
            state <= RUN;
          end else begin
            phCnt <= phCnt + 8'd1;
          end
        end
        RUN: begin
          if (dut_ack) begin
            cycles    <= cnt;
            cyc_valid <= 1'b1;
            state     <= LOG;
          end else if (wdHit) begin
            cycles    <= TIMEOUT_C;
            cyc_valid <= 1'b1;
            state     <= LOG;
          end else begin
            cnt <= cntInc;
          end
        end
        LOG: begin
          if (prog_idx == LAST_IDX) begin
            state <= DONE;
            busy  <= 1'b0;
          end else begin
            prog_idx <= prog_idx + 4'd1;
            phCnt    <= 8'd0;
            state    <= reinit ? INIT : REQ;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_program_sequencer.sv
// Directed bench for program_sequencer: main 3-program instance plus a 4-bit counter instance,
// and a 50-cycle watchdog instance when PSEQ_WATCHDOG_EN is defined.
module tb_program_sequencer;

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_RUN  = 3'd4;

  logic        clk = 1'b0;
  logic        init_n = 1'b0;
  logic        start = 1'b0;
  logic        dut_ack = 1'b0;
  logic        dut_init, dut_req, busy, done, cyc_valid, timeout;
  logic [3:0]  prog_idx;
  logic [15:0] cycles;
  logic [2:0]  dbgState;

  logic        satStart = 1'b0;
  logic        satAck = 1'b0;
  logic        satInit, satReq, satBusy, satDone, satValid, satTimeout;
  logic [3:0]  satIdx;
  logic [3:0]  satCycles;
  logic [2:0]  satState;

  int checks = 0;
  int errors = 0;

  // DUT-side processor model: 0 = ack after delays[prog], 1 = ack stuck high, 2 = never ack
  int          ackMode = 2;
  int          ackRem = 0;
  int          delays[3] = '{10, 20, 5};

  int          initCnt = 0;
  int          reqCnt = 0;
  logic [15:0] obsCyc[$];
  logic [3:0]  obsIdx[$];
  logic [15:0] exp_q[$];

  always #5 clk = ~clk;

  program_sequencer u_dut (
    .clk(clk), .init_n(init_n), .start(start), .dut_ack(dut_ack),
    .dut_init(dut_init), .dut_req(dut_req), .busy(busy), .done(done),
    .prog_idx(prog_idx), .cycles(cycles), .cyc_valid(cyc_valid),
    .timeout(timeout), .dbgState(dbgState)
  );

  program_sequencer #(.NUM_PROGS(1), .CW(4)) u_sat (
    .clk(clk), .init_n(init_n), .start(satStart), .dut_ack(satAck),
    .dut_init(satInit), .dut_req(satReq), .busy(satBusy), .done(satDone),
    .prog_idx(satIdx), .cycles(satCycles), .cyc_valid(satValid),
    .timeout(satTimeout), .dbgState(satState)
  );

`ifdef PSEQ_WATCHDOG_EN
  logic        wdStart = 1'b0;
  logic        wdAck = 1'b0;
  logic        wdInit, wdReq, wdBusy, wdDone, wdValid, wdTimeout;
  logic [3:0]  wdIdx;
  logic [15:0] wdCycles;
  logic [2:0]  wdState;
  int          wdInitCnt = 0;
  logic [15:0] wdObsCyc[$];

  program_sequencer #(.TIMEOUT(50)) u_wd (
    .clk(clk), .init_n(init_n), .start(wdStart), .dut_ack(wdAck),
    .dut_init(wdInit), .dut_req(wdReq), .busy(wdBusy), .done(wdDone),
    .prog_idx(wdIdx), .cycles(wdCycles), .cyc_valid(wdValid),
    .timeout(wdTimeout), .dbgState(wdState)
  );

  always @(negedge clk) begin
    if (wdInit) wdInitCnt++;
    if (wdValid) wdObsCyc.push_back(wdCycles);
  end
`endif

  // Ack is seen by the sequencer N full cycles after the request cycle, giving a count of N.
  always @(negedge clk) begin
    case (ackMode)
      0: begin
        if (dut_req) begin
          ackRem  = delays[prog_idx] + 1;
          dut_ack = 1'b0;
        end else if (ackRem > 0) begin
          ackRem--;
          if (ackRem == 0) dut_ack = 1'b1;
        end
      end
      1: begin ackRem = 0; dut_ack = 1'b1; end
      default: begin ackRem = 0; dut_ack = 1'b0; end
    endcase
  end

  always @(negedge clk) begin
    if (dut_init) initCnt++;
    if (dut_req) reqCnt++;
    if (cyc_valid) begin
      obsCyc.push_back(cycles);
      obsIdx.push_back(prog_idx);
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] expv);
    checks++;
    assert (got === expv) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, expv);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic clearMon();
    initCnt = 0;
    reqCnt  = 0;
    obsCyc.delete();
    obsIdx.delete();
    exp_q.delete();
  endtask

  task automatic pulseStart();
    start = 1'b1;
    tick(1);
    start = 1'b0;
  endtask

  task automatic waitDone(input string tag, input int maxCyc);
    int n = 0;
    while (!done && n < maxCyc) begin
      tick(1);
      n++;
    end
    chk(tag, 32'(done), 32'd1);
  endtask

  task automatic waitRun(input string tag, input int maxCyc);
    int n = 0;
    while (dbgState != S_RUN && n < maxCyc) begin
      tick(1);
      n++;
    end
    chk(tag, 32'(dbgState), 32'(S_RUN));
  endtask

  task automatic cmpReports(input string tag);
    chk($sformatf("%s_count", tag), 32'(obsCyc.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < obsCyc.size(); i++) begin
      chk($sformatf("%s_cycles%0d", tag, i), 32'(obsCyc[i]), 32'(exp_q[i]));
      chk($sformatf("%s_idx%0d", tag, i), 32'(obsIdx[i]), i);
    end
  endtask

  task automatic chkIdleOutputs(input string tag);
    chk({tag, "_state"}, 32'(dbgState), 32'(S_IDLE));
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_done"}, 32'(done), 0);
    chk({tag, "_init"}, 32'(dut_init), 0);
    chk({tag, "_req"}, 32'(dut_req), 0);
    chk({tag, "_valid"}, 32'(cyc_valid), 0);
    chk({tag, "_idx"}, 32'(prog_idx), 0);
    chk({tag, "_cycles"}, 32'(cycles), 0);
    chk({tag, "_timeout"}, 32'(timeout), 0);
  endtask

  initial begin
    int n;

    // Reset state
    tick(3);
    chkIdleOutputs("reset");
    init_n = 1'b1;
    tick(2);

    // Three programs with acks after 10, 20, 5 cycles
    clearMon();
    ackMode = 0;
    start = 1'b1;
    tick(1);
    start = 1'b0;
    chk("run1_busy", 32'(busy), 1);
    chk("run1_init", 32'(dut_init), 1);
    chk("run1_idx", 32'(prog_idx), 0);
    waitDone("run1_done", 300);
    exp_q.push_back(16'd10); exp_q.push_back(16'd20); exp_q.push_back(16'd5);
    cmpReports("run1");
    chk("run1_initcnt", initCnt, 2);
    chk("run1_reqcnt", reqCnt, 3);
    chk("run1_busy_end", 32'(busy), 0);
    chk("run1_timeout", 32'(timeout), 0);
    tick(3);
    chk("run1_hold", 32'(cycles), 5);
    chk("run1_hold_idx", 32'(prog_idx), 2);

    // Stale halt: every program reports only the blank window
    clearMon();
    ackMode = 1;
    pulseStart();
    waitDone("stale_done", 300);
    exp_q.push_back(16'd2); exp_q.push_back(16'd2); exp_q.push_back(16'd2);
    cmpReports("stale");
    chk("stale_reqcnt", reqCnt, 3);
    chk("stale_initcnt", initCnt, 2);

    // Start during RUN is ignored
    clearMon();
    ackMode = 0;
    pulseStart();
    waitRun("busy_run", 50);
    pulseStart();
    chk("busy_ignore_busy", 32'(busy), 1);
    chk("busy_ignore_init", 32'(dut_init), 0);
    waitDone("busy_done", 300);
    exp_q.push_back(16'd10); exp_q.push_back(16'd20); exp_q.push_back(16'd5);
    cmpReports("busy");
    chk("busy_initcnt", initCnt, 2);
    chk("busy_reqcnt", reqCnt, 3);

    // Start held in DONE restarts immediately
    clearMon();
    start = 1'b1;
    tick(1);
    chk("restart_init", 32'(dut_init), 1);
    chk("restart_idx", 32'(prog_idx), 0);
    chk("restart_busy", 32'(busy), 1);
    chk("restart_done", 32'(done), 0);
    chk("restart_timeout", 32'(timeout), 0);
    tick(1);
    start = 1'b0;
    waitDone("restart_end", 300);
    exp_q.push_back(16'd10); exp_q.push_back(16'd20); exp_q.push_back(16'd5);
    cmpReports("restart");
    chk("restart_initcnt", initCnt, 2);

    // Reset in the middle of RUN
    clearMon();
    ackMode = 2;
    pulseStart();
    waitRun("midrst_run", 50);
    tick(5);
    init_n = 1'b0;
    tick(1);
    init_n = 1'b1;
    chkIdleOutputs("midrst");
    tick(5);
    chk("midrst_novalid", 32'(obsCyc.size()), 0);
    chk("midrst_stay", 32'(dbgState), 32'(S_IDLE));

    // 4-bit counter saturates instead of wrapping
    satStart = 1'b1;
    tick(1);
    satStart = 1'b0;
    n = 0;
    while (!satReq && n < 20) begin tick(1); n++; end
    chk("sat_req", 32'(satReq), 1);
    tick(31);
    satAck = 1'b1;
    n = 0;
    while (!satValid && n < 10) begin tick(1); n++; end
    chk("sat_valid", 32'(satValid), 1);
    chk("sat_cycles", 32'(satCycles), 15);
    chk("sat_idx", 32'(satIdx), 0);
    tick(1);
    satAck = 1'b0;
    chk("sat_done", 32'(satDone), 1);

`ifdef PSEQ_WATCHDOG_EN
    // Processor never halts: each program times out at 50 and is re-initialised
    wdStart = 1'b1;
    tick(1);
    wdStart = 1'b0;
    n = 0;
    while (!wdDone && n < 400) begin tick(1); n++; end
    chk("wd_done", 32'(wdDone), 1);
    chk("wd_timeout", 32'(wdTimeout), 1);
    chk("wd_count", 32'(wdObsCyc.size()), 3);
    for (int i = 0; i < wdObsCyc.size(); i++)
      chk($sformatf("wd_cycles%0d", i), 32'(wdObsCyc[i]), 50);
    chk("wd_initcnt", wdInitCnt, 6);
    wdStart = 1'b1;
    tick(1);
    wdStart = 1'b0;
    chk("wd_clear", 32'(wdTimeout), 0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
